// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register-file write scoreboard.
package reg_scoreboard_pkg;
    localparam int unsigned REG_AW      = 5;
    localparam int unsigned NUM_REGS    = 32;
    localparam int unsigned CNT_W_DEF   = 2;
    localparam int unsigned STALL_W_DEF = 16;
endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter: saturating up/down, inc+dec together holds the value.
module sb_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_zero,
    output logic o_full,
    output logic o_nz_next
);
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count;
        if (i_inc && !i_dec && (r_count != '1)) begin
            w_count_d = r_count + 1'b1;
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            w_count_d = r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_d;
        end
    end

    assign o_zero    = (r_count == '0);
    assign o_full    = (r_count == '1);
    assign o_nz_next = (w_count_d != '0);
endmodule

// File: rtl/reg_scoreboard.sv
// Register-file write scoreboard: stalls issue on RAW hazards and pending-write saturation,
// tracks busy state, a saturating stall counter and a sticky writeback-underflow flag.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned STALL_W = STALL_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_issue_valid,
    input  logic [REG_AW-1:0] i_issue_rs,
    input  logic [REG_AW-1:0] i_issue_rt,
    input  logic              i_issue_use_rs,
    input  logic              i_issue_use_rt,
    input  logic              i_issue_we,
    input  logic [REG_AW-1:0] i_issue_rd,
    input  logic              i_wb_valid,
    input  logic [REG_AW-1:0] i_wb_a3,
    output logic              o_stall,
    output logic              o_busy,
    output logic [STALL_W-1:0] o_stall_cnt,
    output logic              o_err_underflow
);
    logic [NUM_REGS-1:0] w_nz;
    logic [NUM_REGS-1:0] w_full;
    logic [NUM_REGS-1:0] w_nz_next;
    logic                w_accept;
    logic                w_underflow;
    logic                r_busy;
    logic                r_err;
    logic [STALL_W-1:0]  r_stall_cnt;

    // Register 0 is never tracked, so its status bits are tied low.
    assign w_nz[0]      = 1'b0;
    assign w_full[0]    = 1'b0;
    assign w_nz_next[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        logic w_inc;
        logic w_dec;
        logic w_zero;

        assign w_inc = w_accept && i_issue_we && (i_issue_rd == REG_AW'(r));
        assign w_dec = i_wb_valid && (i_wb_a3 == REG_AW'(r)) && w_nz[r];

        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_inc     (w_inc),
            .i_dec     (w_dec),
            .o_zero    (w_zero),
            .o_full    (w_full[r]),
            .o_nz_next (w_nz_next[r])
        );

        assign w_nz[r] = ~w_zero;
    end

    // Hazards use pre-edge pending state only; a same-cycle writeback does not bypass.
    assign o_stall = i_issue_valid &&
                     ((i_issue_use_rs && (i_issue_rs != '0) && w_nz[i_issue_rs]) ||
                      (i_issue_use_rt && (i_issue_rt != '0) && w_nz[i_issue_rt]) ||
                      (i_issue_we     && (i_issue_rd != '0) && w_full[i_issue_rd]));

    assign w_accept    = i_issue_valid && !o_stall;
    assign w_underflow = i_wb_valid && (i_wb_a3 != '0) && !w_nz[i_wb_a3];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_busy <= |w_nz_next;
            r_err  <= r_err | w_underflow;
            if (o_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign o_busy          = r_busy;
    assign o_err_underflow = r_err;
    assign o_stall_cnt     = r_stall_cnt;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench: stimulus pushes model expectations, a monitor pops and compares.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    localparam int unsigned CNT_W   = 2;
    localparam int unsigned STALL_W = 16;
    localparam int          MAXV    = (1 << CNT_W) - 1;
    localparam int          SMAX    = (1 << STALL_W) - 1;

    typedef struct {
        bit busy;
        bit err;
        int cnt;
    } post_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               issue_valid = 1'b0;
    logic [REG_AW-1:0]  issue_rs = '0;
    logic [REG_AW-1:0]  issue_rt = '0;
    logic               issue_use_rs = 1'b0;
    logic               issue_use_rt = 1'b0;
    logic               issue_we = 1'b0;
    logic [REG_AW-1:0]  issue_rd = '0;
    logic               wb_valid = 1'b0;
    logic [REG_AW-1:0]  wb_a3 = '0;
    logic               stall;
    logic               busy;
    logic [STALL_W-1:0] stall_cnt;
    logic               err_underflow;

    int n_cmp = 0;
    int n_fail = 0;

    bit    q_stall[$];
    post_t q_post[$];

    int m_pend[NUM_REGS];
    bit m_err;
    int m_scnt;

    reg_scoreboard #(
        .CNT_W   (CNT_W),
        .STALL_W (STALL_W)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_issue_valid   (issue_valid),
        .i_issue_rs      (issue_rs),
        .i_issue_rt      (issue_rt),
        .i_issue_use_rs  (issue_use_rs),
        .i_issue_use_rt  (issue_use_rt),
        .i_issue_we      (issue_we),
        .i_issue_rd      (issue_rd),
        .i_wb_valid      (wb_valid),
        .i_wb_a3         (wb_a3),
        .o_stall         (stall),
        .o_busy          (busy),
        .o_stall_cnt     (stall_cnt),
        .o_err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        foreach (m_pend[i]) m_pend[i] = 0;
        m_err  = 1'b0;
        m_scnt = 0;
    endfunction

    function automatic bit model_busy();
        foreach (m_pend[i]) if (m_pend[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Drive one cycle of stimulus and queue what the spec says must happen.
    task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input bit we, input int rd, input bit wbv, input int wba);
        bit    st;
        post_t p;
        @(negedge clk);
        issue_valid  = v;
        issue_rs     = REG_AW'(rs);
        issue_rt     = REG_AW'(rt);
        issue_use_rs = urs;
        issue_use_rt = urt;
        issue_we     = we;
        issue_rd     = REG_AW'(rd);
        wb_valid     = wbv;
        wb_a3        = REG_AW'(wba);
        st = v && ((urs && rs != 0 && m_pend[rs] != 0) ||
                   (urt && rt != 0 && m_pend[rt] != 0) ||
                   (we && rd != 0 && m_pend[rd] == MAXV));
        if (wbv && wba != 0) begin
            if (m_pend[wba] == 0) m_err = 1'b1;
            else m_pend[wba] = m_pend[wba] - 1;
        end
        if (v && !st && we && rd != 0) m_pend[rd] = m_pend[rd] + 1;
        if (st && m_scnt < SMAX) m_scnt = m_scnt + 1;
        p.busy = model_busy();
        p.err  = m_err;
        p.cnt  = m_scnt;
        q_stall.push_back(st);
        q_post.push_back(p);
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_use_rs = 1'b0; issue_use_rt = 1'b0; issue_we = 1'b0;
        wb_valid = 1'b0; issue_rs = '0; issue_rt = '0; issue_rd = '0; wb_a3 = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_err", 32'(err_underflow), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor_stall
        forever begin
            @(negedge clk);
            #2;
            if (q_stall.size() > 0) chk("stall", 32'(stall), 32'(q_stall.pop_front()));
        end
    end

    initial begin : monitor_post
        post_t p;
        forever begin
            @(posedge clk);
            #1;
            if (q_post.size() > 0) begin
                p = q_post.pop_front();
                chk("busy", 32'(busy), 32'(p.busy));
                chk("err_underflow", 32'(err_underflow), 32'(p.err));
                chk("stall_cnt", 32'(stall_cnt), 32'(p.cnt));
            end
        end
    end

    initial begin : stimulus
        idle_inputs();
        model_reset();
        do_reset();

        // RAW on r8 resolved only after writeback edge
        step(1, 0, 0, 0, 0, 1, 8, 0, 0);
        step(1, 8, 0, 1, 0, 0, 0, 0, 0);
        step(1, 8, 0, 1, 0, 0, 0, 1, 8);
        step(1, 8, 0, 1, 0, 0, 0, 0, 0);
        // r5 saturates at 3 outstanding writes
        repeat (3) step(1, 0, 0, 0, 0, 1, 5, 0, 0);
        step(1, 0, 0, 0, 0, 1, 5, 0, 0);
        step(1, 0, 0, 0, 0, 1, 5, 1, 5);
        step(1, 0, 0, 0, 0, 1, 5, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 5);
        // same-cycle issue and writeback on r9
        step(1, 0, 0, 0, 0, 1, 9, 0, 0);
        step(1, 0, 0, 0, 0, 1, 9, 1, 9);
        step(1, 9, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 9);
        // register 0 is never tracked
        step(1, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 1, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            step(bit'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)), $urandom_range(0, 7),
                 bit'($urandom_range(0, 1)), $urandom_range(0, 7));
        end

        do_reset();
        // underflow on r3 is sticky
        step(0, 0, 0, 0, 0, 0, 0, 1, 3);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // saturate the stall counter
        step(1, 0, 0, 0, 0, 1, 8, 0, 0);
        for (int i = 0; i < 70000; i++) step(1, 8, 0, 1, 0, 0, 0, 0, 0);

        // asynchronous reset mid-operation, issue still presented
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_cnt", 32'(stall_cnt), 32'd0);
        chk("async_rst_err", 32'(err_underflow), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // discarded pending write on r8 now underflows
        step(0, 0, 0, 0, 0, 0, 0, 1, 8);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("queues_drained", 32'(q_stall.size() + q_post.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
